imem_resp_pipe: RTL and testbench

- Parametrised instruction-memory responder for the LC3 fetch path.
- Accepts PC read requests (PC/instrmem_rd) and returns instr_dout/complete_instr after a configurable latency.
- Supports multiple outstanding requests, a response FIFO with consumer back-pressure, and a flush for branch redirects.
- Replaces the single-outstanding, fixed-width imem responder. Used as synthesizable DUT-side memory and as the reference model behind the imem agent.

---
 rtl/imem_pipe_pkg.sv | 38 +++
 rtl/imem_rsp_fifo.sv | 66 ++++++
 rtl/imem_resp_pipe.sv | 143 ++++++++++++++
 tb/tb_imem_resp_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pipe_pkg.sv
// imem_pipe_pkg: shared types and constants for the instruction-memory
// responder (imem_resp_pipe) and its response FIFO (imem_rsp_fifo).
//   imem_req_t / imem_rsp_t : request address / response data records
//   idx_width / cnt_width   : word-index and occupancy-counter widths
//   latency_ok              : legal LATENCY range check (1..8)
package imem_pipe_pkg;

  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 16;

  typedef struct packed {
    logic [IMEM_ADDR_W-1:0] addr;
  } imem_req_t;

  typedef struct packed {
    logic [IMEM_DATA_W-1:0] data;
  } imem_rsp_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;

  function automatic int idx_width(input int words);
    return $clog2(words);
  endfunction

  // Counter must be able to hold the value DEPTH itself, hence DEPTH+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit latency_ok(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

  localparam int IDX_W_DEFAULT = idx_width(1024);
  localparam int CNT_W_DEFAULT = cnt_width(4);

endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: synchronous FIFO with flush and registered occupancy count.
// Ports:
//   clock, reset (sync, active-low), flush (clears contents)
//   push, push_data          : write side (caller guarantees space)
//   pop                      : remove head when non-empty
//   head, not_empty          : head entry (0 when empty) and valid flag
//   count                    : registered number of stored entries
module imem_rsp_fifo
  import imem_pipe_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head,
  output logic                        not_empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] slots [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_pop;

  assign do_pop    = pop && (cnt != '0);
  assign not_empty = (cnt != '0);
  assign head      = not_empty ? slots[rd_ptr] : '0;
  assign count     = cnt;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset && !flush && push) begin
      assert (cnt < CNT_W'(DEPTH) || do_pop);
    end
  end

endmodule

// File: rtl/imem_resp_pipe.sv
// imem_resp_pipe: instruction memory with fixed-latency, multi-outstanding
// read responses, a response FIFO with consumer back-pressure, and flush.
// Ports:
//   clock, reset (sync, active-low)
//   PC, instrmem_rd, req_ready         : request side
//   instr_dout, complete_instr, resp_ready : response side
//   flush                              : drop all in-flight/queued responses
//   load_en, load_addr, load_data      : preload write port
//   outstanding                        : in-flight plus queued count
//
// Handshakes: a request transfers at a rising edge where instrmem_rd and
// req_ready are both 1; a response transfers at a rising edge where
// complete_instr and resp_ready are both 1. A valid response holds its data
// stable until it transfers.
module imem_resp_pipe
  import imem_pipe_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          PC,
  input  logic                       instrmem_rd,
  output logic                       req_ready,
  output logic [DATA_W-1:0]          instr_dout,
  output logic                       complete_instr,
  input  logic                       resp_ready,
  input  logic                       flush,
  input  logic                       load_en,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic [DATA_W-1:0]          load_data,
  output logic [$clog2(DEPTH+1)-1:0] outstanding
);

  localparam int IDX_W  = idx_width(MEM_WORDS);
  localparam int CNT_W  = cnt_width(DEPTH);
  localparam bit LAT_OK = latency_ok(LATENCY);

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]  pc_idx;
  logic [IDX_W-1:0]  load_idx;
  logic [DATA_W-1:0] rd_data;
  logic              accept;
  logic              pop;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic [CNT_W-1:0]  outstanding_q;
  logic [CNT_W-1:0]  fifo_count;

  assign pc_idx   = PC[IDX_W-1:0];
  assign load_idx = load_addr[IDX_W-1:0];

  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      logic unused_hi;
      assign unused_hi = ^{PC[ADDR_W-1:IDX_W], load_addr[ADDR_W-1:IDX_W]};
    end
  endgenerate

  // Credit check uses the registered count: a pop in this cycle frees its
  // slot only from the next cycle on.
  assign req_ready = reset && !flush && (outstanding_q < CNT_W'(DEPTH));
  assign accept    = instrmem_rd && req_ready;
  assign pop       = complete_instr && resp_ready;
  assign outstanding = outstanding_q;

  // Read and write share the edge; the read sees the pre-write contents.
  assign rd_data = mem[pc_idx];

  always_ff @(posedge clock) begin
    if (load_en) mem[load_idx] <= load_data;
  end

  // LATENCY-1 delay stages in front of the FIFO. With LATENCY=1 the read
  // data goes straight into the FIFO at the acceptance edge.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_valid = accept;
      assign push_data  = rd_data;
    end else begin : g_stages
      localparam int NSTG = LATENCY - 1;
      logic [NSTG-1:0]   stg_valid;
      logic [DATA_W-1:0] stg_data [NSTG];

      always_ff @(posedge clock) begin
        if (!reset || flush) begin
          stg_valid <= '0;
        end else begin
          stg_valid[0] <= accept;
          for (int i = 1; i < NSTG; i++) stg_valid[i] <= stg_valid[i-1];
        end
      end

      always_ff @(posedge clock) begin
        stg_data[0] <= rd_data;
        for (int i = 1; i < NSTG; i++) stg_data[i] <= stg_data[i-1];
      end

      assign push_valid = stg_valid[NSTG-1];
      assign push_data  = stg_data[NSTG-1];
    end
  endgenerate

  imem_rsp_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (instr_dout),
    .not_empty (complete_instr),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      outstanding_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    assert (LAT_OK);
    if (reset) begin
      assert (outstanding_q <= CNT_W'(DEPTH));
      assert (fifo_count <= outstanding_q);
    end
  end

endmodule

// File: tb/tb_imem_resp_pipe.sv
// tb_imem_resp_pipe: self-checking bench for imem_resp_pipe (default
// parameters). A transaction-level model keeps every accepted request with
// the cycle at which it becomes presentable; outputs are compared against it
// every cycle, plus directed value checks from the test plan.
module tb_imem_resp_pipe;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int MEM_WORDS = 1024;
  localparam int LATENCY   = 2;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int IDX_W     = $clog2(MEM_WORDS);

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] PC;
  logic              instrmem_rd;
  logic              req_ready;
  logic [DATA_W-1:0] instr_dout;
  logic              complete_instr;
  logic              resp_ready;
  logic              flush;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [CNT_W-1:0]  outstanding;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DATA_W-1:0] model_mem [MEM_WORDS];
  logic [DATA_W-1:0] exp_q[$];
  int                rdy_q[$];

  imem_resp_pipe #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY),
    .DEPTH     (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .PC             (PC),
    .instrmem_rd    (instrmem_rd),
    .req_ready      (req_ready),
    .instr_dout     (instr_dout),
    .complete_instr (complete_instr),
    .resp_ready     (resp_ready),
    .flush          (flush),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .outstanding    (outstanding)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven: compares outputs
  // against the model, advances the model by one rising edge, then returns
  // at the next falling edge.
  task automatic tick();
    logic              exp_cmp;
    logic              exp_rdy;
    logic [DATA_W-1:0] exp_dout;
    #1;
    exp_cmp = 1'b0;
    if (exp_q.size() > 0) exp_cmp = (rdy_q[0] <= cyc);
    exp_dout = exp_cmp ? exp_q[0] : '0;
    exp_rdy  = reset && !flush && (exp_q.size() < DEPTH);

    chk("complete_instr", 32'(complete_instr), 32'(exp_cmp));
    chk("instr_dout", 32'(instr_dout), 32'(exp_dout));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("outstanding", 32'(outstanding), 32'(exp_q.size()));

    if (!reset || flush) begin
      exp_q.delete();
      rdy_q.delete();
    end else begin
      if (exp_cmp && resp_ready) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      if (instrmem_rd && exp_rdy) begin
        // Accepted at the coming edge (cyc+1); presentable LATENCY-1 edges later.
        exp_q.push_back(model_mem[PC[IDX_W-1:0]]);
        rdy_q.push_back(cyc + LATENCY);
      end
    end
    if (load_en) model_mem[load_addr[IDX_W-1:0]] = load_data;

    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  // ---------------- drivers ----------------
  task automatic set_idle();
    instrmem_rd = 1'b0;
    flush       = 1'b0;
    load_en     = 1'b0;
  endtask

  task automatic do_req(input logic [ADDR_W-1:0] addr);
    set_idle();
    PC          = addr;
    instrmem_rd = 1'b1;
    tick();
  endtask

  task automatic do_idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    set_idle();
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b0;
    PC          = '0;
    instrmem_rd = 1'b0;
    resp_ready  = 1'b1;
    flush       = 1'b0;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);

    // Preload the whole array while in reset (outputs checked as reset state).
    for (int i = 0; i < MEM_WORDS; i++) do_load(ADDR_W'(i), DATA_W'($urandom));
    do_load(16'h0010, 16'h1234);
    do_load(16'h0011, 16'h5678);
    do_load(16'h0020, 16'hAAAA);

    reset = 1'b1;
    set_idle();
    #1;
    chk("ready_after_release", 32'(req_ready), 32'd1);
    chk("outstanding_after_release", 32'(outstanding), 32'd0);
    tick();

    // Back-to-back requests, latency 2.
    resp_ready = 1'b1;
    do_req(16'h0010);
    do_req(16'h0011);
    set_idle();
    #1;
    chk("t1_first_valid", 32'(complete_instr), 32'd1);
    chk("t1_first_data", 32'(instr_dout), 32'h1234);
    tick();
    #1;
    chk("t1_second_valid", 32'(complete_instr), 32'd1);
    chk("t1_second_data", 32'(instr_dout), 32'h5678);
    tick();
    do_idle(2);

    // Fill to DEPTH with back-pressure, then drain.
    resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) do_req(ADDR_W'($urandom_range(0, 65535)));
    set_idle();
    #1;
    chk("t2_full_count", 32'(outstanding), 32'd4);
    chk("t2_full_ready", 32'(req_ready), 32'd0);
    do_idle(2);
    resp_ready = 1'b1;
    do_idle(6);

    // Flush with a request present.
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_req(ADDR_W'($urandom_range(0, 65535)));
    do_idle(2);
    set_idle();
    flush       = 1'b1;
    instrmem_rd = 1'b1;
    PC          = 16'h0011;
    #1;
    chk("t3_flush_blocks_ready", 32'(req_ready), 32'd0);
    tick();
    set_idle();
    resp_ready = 1'b1;
    #1;
    chk("t3_count_after_flush", 32'(outstanding), 32'd0);
    chk("t3_valid_after_flush", 32'(complete_instr), 32'd0);
    do_idle(4);

    // Read-before-write at the acceptance edge.
    set_idle();
    PC          = 16'h0020;
    instrmem_rd = 1'b1;
    load_en     = 1'b1;
    load_addr   = 16'h0020;
    load_data   = 16'hBEEF;
    tick();
    do_idle(1);
    #1;
    chk("t4_old_data", 32'(instr_dout), 32'hAAAA);
    do_idle(1);
    do_req(16'h0020);
    do_idle(1);
    #1;
    chk("t4_new_data", 32'(instr_dout), 32'hBEEF);
    do_idle(1);

    // Address wrap modulo MEM_WORDS.
    do_req(16'h0410);
    do_idle(1);
    #1;
    chk("t5_wrap_data", 32'(instr_dout), 32'h1234);
    do_idle(2);

    // Reset with two in flight.
    do_req(16'h0010);
    do_req(16'h0011);
    set_idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("t6_valid_after_reset", 32'(complete_instr), 32'd0);
    chk("t6_dout_after_reset", 32'(instr_dout), 32'd0);
    chk("t6_count_after_reset", 32'(outstanding), 32'd0);
    do_req(16'h0011);
    do_idle(1);
    #1;
    chk("t6_nominal_latency", 32'(instr_dout), 32'h5678);
    do_idle(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      set_idle();
      instrmem_rd = ($urandom_range(0, 2) != 0);
      PC          = ADDR_W'($urandom_range(0, 65535));
      resp_ready  = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      reset       = ($urandom_range(0, 59) != 0);
      load_en     = ($urandom_range(0, 3) == 0);
      load_addr   = ADDR_W'($urandom_range(0, 65535));
      load_data   = DATA_W'($urandom);
      tick();
    end
    reset      = 1'b1;
    resp_ready = 1'b1;
    do_idle(12);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
